// File: rtl/bus_sync_qualified_if.sv
// ---------------------------------------------------------------------------
// bus_sync_qualified_if
// Groups the bus-side signals of bus_sync_qualified.
//   en        : commit enable (low holds data_out, qualification continues)
//   data_in   : asynchronous source-domain bus
//   data_out  : qualified, coherent synchronized bus
//   data_chg  : one-cycle pulse the cycle after data_out updates
//   busy      : a pending value differs from data_out or is still settling
//   rej_cnt   : saturating count of candidates discarded before commit
// Modports: master drives en/data_in, slave (the synchronizer) drives the rest.
// Handshake: there is no valid/ready pair; data_in is sampled on every clk
// edge and data_chg is the only qualifier of data_out, one cycle wide.
// ---------------------------------------------------------------------------
interface bus_sync_qualified_if #(
    parameter int DATAWTH = 8,
    parameter int REJWTH  = 8
);
    logic               en;
    logic [DATAWTH-1:0] data_in;
    logic [DATAWTH-1:0] data_out;
    logic               data_chg;
    logic               busy;
    logic [REJWTH-1:0]  rej_cnt;

    modport master (
        output en, data_in,
        input  data_out, data_chg, busy, rej_cnt
    );

    modport slave (
        input  en, data_in,
        output data_out, data_chg, busy, rej_cnt
    );
endinterface

// File: rtl/bus_sync_qualified.sv
// ---------------------------------------------------------------------------
// bus_sync_qualified
// Brings an asynchronous multi-bit bus into the clk domain through an
// NUMSTGS-deep flop chain, then publishes a new word on data_out only after
// the synchronized word has been stable for STBLCNT consecutive compares.
// Ports:
//   clk      : destination-domain clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : bus_sync_qualified_if.slave (en, data_in in; data_out,
//              data_chg, busy, rej_cnt out)
// ---------------------------------------------------------------------------
module bus_sync_qualified #(
    parameter int                 DATAWTH = 8,
    parameter int                 NUMSTGS = 2,
    parameter int                 STBLCNT = 3,
    parameter logic [DATAWTH-1:0] RSTVAL  = '0,
    parameter int                 REJWTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    bus_sync_qualified_if.slave  bus
);
    localparam int                CNTW    = (STBLCNT < 1) ? 1 : $clog2(STBLCNT + 1);
    localparam logic [CNTW-1:0]   CNT_MAX = CNTW'(STBLCNT);
    localparam logic [CNTW-1:0]   CNT_THR = CNTW'(STBLCNT - 1);
    localparam logic [REJWTH-1:0] REJ_MAX = '1;

    logic [DATAWTH-1:0] stage_q [NUMSTGS];
    logic [DATAWTH-1:0] s;

    logic [DATAWTH-1:0] cand_q, cand_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [DATAWTH-1:0] dout_q, dout_d;
    logic               chg_q, chg_d;
    logic [REJWTH-1:0]  rej_q, rej_d;
    logic               commit;

    assign s = stage_q[NUMSTGS-1];

    // Plain synchronizer chain, one word per stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUMSTGS; i++) stage_q[i] <= RSTVAL;
        end else begin
            stage_q[0] <= bus.data_in;
            for (int i = 1; i < NUMSTGS; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    // cnt counts compares after the candidate loaded, so the threshold is
    // STBLCNT-1: the load edge itself is the first of the STBLCNT+1 cycles.
    assign commit = (s == cand_q) && (cnt_q >= CNT_THR) && bus.en && (cand_q != dout_q);

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        rej_d  = rej_q;
        dout_d = dout_q;
        chg_d  = 1'b0;
        if (s != cand_q) begin
            cand_d = s;
            cnt_d  = '0;
            // Only a candidate that was heading for publication counts as rejected.
            if ((cand_q != dout_q) && (rej_q != REJ_MAX)) rej_d = rej_q + REJWTH'(1);
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNTW'(1);
        end
        if (commit) begin
            dout_d = cand_q;
            chg_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand_q <= RSTVAL;
            cnt_q  <= '0;
            dout_q <= RSTVAL;
            chg_q  <= 1'b0;
            rej_q  <= '0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            chg_q  <= chg_d;
            rej_q  <= rej_d;
        end
    end

    assign bus.data_out = dout_q;
    assign bus.data_chg = chg_q;
    assign bus.rej_cnt  = rej_q;
    assign bus.busy     = (cand_q != dout_q) || (s != cand_q);
endmodule

// File: tb/tb_bus_sync_qualified.sv
module tb_bus_sync_qualified;
    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // a: defaults, b: REJWTH=2, c: NUMSTGS=3 STBLCNT=1
    bus_sync_qualified_if #(.DATAWTH(8), .REJWTH(8)) if_a ();
    bus_sync_qualified_if #(.DATAWTH(8), .REJWTH(2)) if_b ();
    bus_sync_qualified_if #(.DATAWTH(8), .REJWTH(8)) if_c ();

    bus_sync_qualified #(.DATAWTH(8), .NUMSTGS(2), .STBLCNT(3), .RSTVAL(8'h00), .REJWTH(8))
        dut_a (.clk(clk), .reset_n(reset_n), .bus(if_a));
    bus_sync_qualified #(.DATAWTH(8), .NUMSTGS(2), .STBLCNT(3), .RSTVAL(8'h00), .REJWTH(2))
        dut_b (.clk(clk), .reset_n(reset_n), .bus(if_b));
    bus_sync_qualified #(.DATAWTH(8), .NUMSTGS(3), .STBLCNT(1), .RSTVAL(8'h00), .REJWTH(8))
        dut_c (.clk(clk), .reset_n(reset_n), .bus(if_c));

    // ---------------- driver tasks ----------------
    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int pulses;

    initial begin
        if_a.en = 1'b1; if_a.data_in = 8'h00;
        if_b.en = 1'b1; if_b.data_in = 8'h00;
        if_c.en = 1'b1; if_c.data_in = 8'h00;
        step(2);
        reset_n = 1'b1;
        step(2);

        // ---- reset state ----
        check("rst_data_out", 32'(if_a.data_out), 32'h00);
        check("rst_data_chg", 32'(if_a.data_chg), 32'h0);
        check("rst_rej_cnt",  32'(if_a.rej_cnt),  32'h0);
        check("rst_busy",     32'(if_a.busy),     32'h0);

        // ---- clean change 0x00 -> 0xA5, commit on E0+5 ----
        if_a.data_in = 8'hA5;
        step(5);                                   // past E0..E0+4
        check("clean_before_out", 32'(if_a.data_out), 32'h00);
        check("clean_before_chg", 32'(if_a.data_chg), 32'h0);
        check("clean_before_busy", 32'(if_a.busy),    32'h1);
        step(1);                                   // past E0+5
        check("clean_out",  32'(if_a.data_out), 32'hA5);
        check("clean_chg",  32'(if_a.data_chg), 32'h1);
        check("clean_busy", 32'(if_a.busy),     32'h0);
        step(1);
        check("clean_chg_drop", 32'(if_a.data_chg), 32'h0);
        check("clean_rej",      32'(if_a.rej_cnt),  32'h0);

        // back to 0x00 (returning change is a normal commit, not a rejection)
        if_a.data_in = 8'h00;
        step(10);
        check("ret_out", 32'(if_a.data_out), 32'h00);
        check("ret_rej", 32'(if_a.rej_cnt),  32'h0);

        // ---- glitch 0x5A for two cycles ----
        if_a.data_in = 8'h5A;
        step(2);
        if_a.data_in = 8'h00;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("glitch_chg", 32'(if_a.data_chg), 32'h0);
            check("glitch_out", 32'(if_a.data_out), 32'h00);
        end
        check("glitch_rej",  32'(if_a.rej_cnt), 32'h1);
        check("glitch_busy", 32'(if_a.busy),    32'h0);

        // ---- skewed bits: 0x0F for one cycle, then 0xFF ----
        if_a.data_in = 8'h0F;
        step(1);
        if_a.data_in = 8'hFF;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("skew_no_partial", 32'(if_a.data_out != 8'h0F), 32'h1);
            if (if_a.data_chg) pulses++;
        end
        check("skew_out",    32'(if_a.data_out), 32'hFF);
        check("skew_pulses", 32'(pulses),        32'd1);
        check("skew_rej",    32'(if_a.rej_cnt),  32'h2);   // 0x0F candidate discarded

        // ---- enable hold: settle on 0x77 with en low for 20 cycles ----
        if_a.en = 1'b0;
        if_a.data_in = 8'h77;
        step(2);                                   // s shows 0x77 after E0+1
        for (int i = 0; i < 20; i++) begin
            check("hold_busy", 32'(if_a.busy),     32'h1);
            check("hold_out",  32'(if_a.data_out), 32'hFF);
            check("hold_chg",  32'(if_a.data_chg), 32'h0);
            step(1);
        end
        if_a.en = 1'b1;
        step(1);                                   // first edge with en high
        check("hold_commit_out", 32'(if_a.data_out), 32'h77);
        check("hold_commit_chg", 32'(if_a.data_chg), 32'h1);
        step(1);
        check("hold_chg_drop",   32'(if_a.data_chg), 32'h0);
        check("hold_busy_after", 32'(if_a.busy),     32'h0);
        check("hold_rej",        32'(if_a.rej_cnt),  32'h2);

        // ---- asynchronous reset mid-run with data_out = 0x3C ----
        if_a.data_in = 8'h3C;
        step(8);
        check("pre_rst_out", 32'(if_a.data_out), 32'h3C);
        #2;
        reset_n = 1'b0;
        #1;                                         // well before next posedge
        check("arst_out",  32'(if_a.data_out), 32'h00);
        check("arst_chg",  32'(if_a.data_chg), 32'h0);
        check("arst_rej",  32'(if_a.rej_cnt),  32'h0);
        check("arst_busy", 32'(if_a.busy),     32'h0);
        if_a.data_in = 8'h00;
        step(2);
        reset_n = 1'b1;
        step(3);
        check("post_rst_out", 32'(if_a.data_out), 32'h00);

        // ---- saturation: REJWTH=2, five glitches -> 3 and holds ----
        for (int g = 1; g <= 5; g++) begin
            if_b.data_in = 8'h5A;
            step(2);
            if_b.data_in = 8'h00;
            step(6);
            check("sat_rej", 32'(if_b.rej_cnt), (g > 3) ? 32'd3 : 32'(g));
            check("sat_out", 32'(if_b.data_out), 32'h00);
        end

        // ---- NUMSTGS=3, STBLCNT=1: clean change commits on E0+4 ----
        if_c.data_in = 8'hA5;
        step(4);                                   // past E0..E0+3
        check("p_before_out", 32'(if_c.data_out), 32'h00);
        check("p_before_chg", 32'(if_c.data_chg), 32'h0);
        step(1);                                   // past E0+4
        check("p_out", 32'(if_c.data_out), 32'hA5);
        check("p_chg", 32'(if_c.data_chg), 32'h1);
        step(1);
        check("p_chg_drop", 32'(if_c.data_chg), 32'h0);
        check("p_busy",     32'(if_c.busy),     32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bus_sync_qualified.md
# bus_sync_qualified

Parametrised successor to the plain multi-stage bus synchronizer for the PCIe sync library. It brings an asynchronous multi-bit bus into the `clk` domain through an NUMSTGS-deep flop chain. It publishes a new value on `data_out` only after the synchronized bus has been stable for STBLCNT consecutive cycles, so skewed or glitching bits never produce an incoherent output word. It also adds an enable/hold control, a one-cycle change strobe, and a saturating count of rejected (unstable) transitions for debug.

## Interface
- DATAWTH, 8, bus width in bits (>=1)
- NUMSTGS, 2, synchronizer flop stages per bit (>=2)
- STBLCNT, 3, consecutive stable compares required before commit (>=1)
- RSTVAL, {DATAWTH{1'b0}}, reset value of sync stages, candidate and `data_out`
- REJWTH, 8, width of the rejected-transition counter (>=1)
- clk  input  1  destination-domain clock; all logic on its rising edge
- reset_n  input  1  asynchronous active-low reset
- en  input  1  commit enable; low holds `data_out`, qualification continues
- data_in  input  DATAWTH  asynchronous source-domain bus
- data_out  output  DATAWTH  qualified, coherent synchronized bus (register)
- data_chg  output  1  one-cycle pulse, high the cycle after `data_out` updates (register)
- busy  output  1  high while a pending value differs from `data_out` or is still settling
- rej_cnt  output  REJWTH  saturating count of candidates discarded before commit (register)

## Operation
- Reset (reset_n low, asynchronous): all stages, `cand`, `data_out` = RSTVAL; `cnt` = 0; `data_chg` = 0; `rej_cnt` = 0. Takes effect immediately, including mid-qualification. The pending candidate is lost.
- Sync chain: stage[0] <= data_in, stage[i] <= stage[i-1]. Let `s` = stage[NUMSTGS-1].
- Candidate tracking, every edge:
  - s != cand: cand <= s; cnt <= 0. If cand != data_out (a candidate was pending), rej_cnt <= rej_cnt+1, saturating at all-ones.
  - s == cand and cnt < STBLCNT: cnt <= cnt+1. cnt saturates at STBLCNT.
- Commit condition: s == cand && cnt >= STBLCNT-1 && en && cand != data_out. On commit, data_out <= cand and data_chg <= 1. In all other cycles data_chg <= 0.
- en low: no commit. cnt keeps saturating. When en rises with a stable, differing cand, commit on that edge.
- Candidate equal to data_out (bus returned to old value): no commit, no data_chg, not counted as rejected.
- busy = (cand != data_out) || (s != cand). Combinational from registers, no input paths.
- No partial-word update: data_out changes only as a whole word taken from cand.

## Timing
- Let E0 be the edge on which stage[0] first captures a new stable data_in.
- s shows it after edge E0+NUMSTGS-1. cand loads on E0+NUMSTGS. Commit occurs on E0+NUMSTGS+STBLCNT.
- Defaults: data_out updates on E0+5. data_chg is high from E0+5 to E0+6.
- Minimum stable width for data_in to be published: STBLCNT+1 clk cycles at s.
- Back-to-back stable changes: at most one commit every STBLCNT+1 cycles. data_chg pulses never merge; each pulse is exactly one cycle.
- First edge after reset_n deassertion behaves as a normal cycle from the reset state.

## Test plan
- Reset values: assert reset_n low mid-run with data_out=0x3C -> data_out=0x00, data_chg=0, rej_cnt=0, busy=0 asynchronously, before the next clk edge.
- Clean change: data_in 0x00->0xA5 before E0, en=1, defaults -> data_out=0xA5 after E0+5, data_chg=1 for exactly one cycle, busy low after E0+5.
- Glitch reject: data_in 0x00->0x5A for 2 cycles, then 0x00, STBLCNT=3 -> data_out stays 0x00, data_chg never asserts, rej_cnt increments to 1.
- Skewed bits: bits [3:0] change to 0xF one cycle before bits [7:4] (target 0xFF) -> data_out goes 0x00->0xFF directly, never shows 0x0F, single data_chg.
- Enable hold: en=0 while data_in settles to 0x77 for 20 cycles, then en=1 -> commit on the first edge with en=1, data_out=0x77, one data_chg pulse; busy high throughout the hold.
- Saturation and parameters: REJWTH=2, inject 5 glitches -> rej_cnt=3 and holds. Rerun the clean-change case with NUMSTGS=3, STBLCNT=1 -> commit on E0+4.
